input_port_ctrl: RTL and testbench

INPUT_PORT_CTRL -- requirements
Module: input_port_ctrl

---
 rtl/input_port_ctrl_if.sv | 38 +++
 rtl/input_port_ctrl.sv | 153 +++++++++++++++
 tb/tb_input_port_ctrl.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/input_port_ctrl_if.sv
// Upstream/downstream bundle of one router input port.
// With INPUT_PORT_ROUTE_ERR_EN the bundle also carries routeErr/errCount.
interface input_port_ctrl_if #(
    parameter int NUM_PORTS = 5,
    parameter int FLIT_W    = 16
);
    logic                 validIn;
    logic [FLIT_W-1:0]    dataIn;
    logic                 ready;
    logic [NUM_PORTS-1:0] outputAvailable;
    logic [NUM_PORTS-1:0] outputGrant;
    logic [NUM_PORTS-1:0] outputReady;
    logic [NUM_PORTS-1:0] requestPort;
    logic [NUM_PORTS-1:0] outValid;
    logic [FLIT_W-1:0]    dataOut;
`ifdef INPUT_PORT_ROUTE_ERR_EN
    logic                 routeErr;
    logic [7:0]           errCount;
`endif

    modport master (
        output validIn, dataIn,
        output outputAvailable, outputGrant, outputReady,
        input  ready, requestPort, outValid, dataOut
`ifdef INPUT_PORT_ROUTE_ERR_EN
        , input routeErr, errCount
`endif
    );

    modport slave (
        input  validIn, dataIn,
        input  outputAvailable, outputGrant, outputReady,
        output ready, requestPort, outValid, dataOut
`ifdef INPUT_PORT_ROUTE_ERR_EN
        , output routeErr, errCount
`endif
    );
endinterface

// File: rtl/input_port_ctrl.sv
// Router input port: flit FIFO plus IDLE/REQUEST/TRANSFER port-lock FSM.
// Optional INPUT_PORT_ROUTE_ERR_EN drops packets with an invalid destination.
module input_port_ctrl #(
    parameter int NUM_PORTS = 5,
    parameter int FLIT_W    = 16,
    parameter int DEPTH     = 4
) (
    input logic               clk,
    input logic               reset_n,
    input_port_ctrl_if.slave  link
);
    localparam int DEST_W = $clog2(NUM_PORTS);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, REQUEST, TRANSFER} state_t;

    logic [FLIT_W-1:0]    mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;
    state_t               state;
    logic [DEST_W-1:0]    out_port;
    logic [NUM_PORTS-1:0] request;
    logic [NUM_PORTS-1:0] port_sel;
    logic [DEST_W-1:0]    dest_raw;
    logic [DEST_W-1:0]    dest;
    logic                 push;
    logic                 pop;
    logic                 drop;
    logic                 empty;
    logic                 fire;
    logic                 head_first;
    logic                 head_last;
    logic                 route_bad;

    assign empty      = count == '0;
    assign link.ready = count != CNT_W'(DEPTH);
    assign push       = link.validIn & link.ready;

    assign link.dataOut = mem[rd_ptr];
    assign head_first   = link.dataOut[FLIT_W-1];
    assign head_last    = link.dataOut[FLIT_W-1] ^ link.dataOut[FLIT_W-2];
    assign dest_raw     = link.dataOut[FLIT_W-3 -: DEST_W];
    assign route_bad    = int'(dest_raw) >= NUM_PORTS;

`ifdef INPUT_PORT_ROUTE_ERR_EN
    assign dest = dest_raw;
`else
    // Out-of-range destinations fall through to the last port.
    assign dest = route_bad ? DEST_W'(NUM_PORTS - 1) : dest_raw;
`endif

    assign fire     = (state == TRANSFER) && !empty
                      && link.outputReady[out_port];
    assign port_sel = NUM_PORTS'(1) << out_port;

    assign link.outValid    = fire ? port_sel : '0;
    assign link.requestPort = request;

    always_comb begin
        pop  = fire;
        drop = 1'b0;
        if (state == IDLE && !empty) begin
            if (!head_first) begin
                pop = 1'b1;
            end
`ifdef INPUT_PORT_ROUTE_ERR_EN
            else if (route_bad) begin
                pop  = 1'b1;
                drop = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= link.dataIn;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (!push && pop) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            out_port <= '0;
            request  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!empty && head_first && !drop
                        && link.outputAvailable[dest]) begin
                        out_port <= dest;
                        request  <= NUM_PORTS'(1) << dest;
                        state    <= REQUEST;
                    end
                end
                REQUEST: begin
                    if (link.outputGrant[out_port]) begin
                        state <= TRANSFER;
                    end
                end
                TRANSFER: begin
                    if (fire && head_last) begin
                        request <= '0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef INPUT_PORT_ROUTE_ERR_EN
    logic       route_err;
    logic [7:0] err_count;

    assign link.routeErr = route_err;
    assign link.errCount = err_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            route_err <= 1'b0;
            err_count <= '0;
        end else begin
            route_err <= drop;
            if (drop && err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_input_port_ctrl.sv
// Directed bench for input_port_ctrl (NUM_PORTS=5, FLIT_W=16, DEPTH=4).
// Delivered flits are logged by a monitor and compared to expected lists.
module tb_input_port_ctrl;
    logic clk = 1'b0;
    logic reset_n = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int viol = 0;
    int err_pulses = 0;

    logic [31:0] log_q[$];
    logic [31:0] exp_q[$];

    input_port_ctrl_if #(.NUM_PORTS(5), .FLIT_W(16)) link ();

    input_port_ctrl #(
        .NUM_PORTS(5),
        .FLIT_W(16),
        .DEPTH(4)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .link(link)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ent(
        input logic [4:0] p, input logic [15:0] d);
        return {11'b0, p, d};
    endfunction

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_log(input string tag);
        check({tag, "_len"}, log_q.size(), exp_q.size());
        for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
            check(tag, log_q[i], exp_q[i]);
        end
    endtask

    task automatic push(input logic [15:0] d);
        int n = 0;
        @(negedge clk);
        link.validIn = 1'b1;
        link.dataIn  = d;
        #1;
        while (!link.ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!link.ready) check("push_timeout", 0, 1);
    endtask

    task automatic stop_in();
        @(negedge clk);
        link.validIn = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Simple arbiter: grant whatever is requested.
    initial begin
        link.outputGrant = '0;
        forever begin
            @(negedge clk);
            link.outputGrant = link.requestPort;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (reset_n && link.outValid != '0) begin
                log_q.push_back(ent(link.outValid, link.dataOut));
            end
            if ($countones(link.outValid) > 1) viol++;
            if ($countones(link.requestPort) > 1) viol++;
`ifdef INPUT_PORT_ROUTE_ERR_EN
            if (link.routeErr) err_pulses++;
`endif
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [15:0] s1_din [7] = '{16'hD011, 16'h0022, 16'h4033,
                                16'h0, 16'h0, 16'h0, 16'h0};
    logic        s1_vin [7] = '{1, 1, 1, 0, 0, 0, 0};
    logic [4:0]  s1_req [7] = '{0, 0, 4, 4, 4, 4, 0};
    logic [4:0]  s1_val [7] = '{0, 0, 0, 4, 4, 4, 0};
    logic [15:0] s1_dat [7] = '{16'h0, 16'h0, 16'h0, 16'hD011,
                                16'h0022, 16'h4033, 16'h0};

    initial begin
        int first;
        int nreq;
        link.validIn = 1'b0;
        link.dataIn  = '0;
        link.outputAvailable = 5'b11111;
        link.outputReady     = 5'b11111;

        // Reset values
        wait_cycles(2);
        #1;
        check("rst_ready", link.ready, 1);
        check("rst_req", link.requestPort, 0);
        check("rst_val", link.outValid, 0);
`ifdef INPUT_PORT_ROUTE_ERR_EN
        check("rst_errcnt", link.errCount, 0);
`endif
        @(negedge clk);
        reset_n = 1'b1;

        // 3-flit packet to port 2, minimum latency
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            link.validIn = s1_vin[k];
            link.dataIn  = s1_din[k];
            #1;
            if (k == 0) check("s1_ready", link.ready, 1);
            check($sformatf("s1_req_c%0d", k), link.requestPort, s1_req[k]);
            check($sformatf("s1_val_c%0d", k), link.outValid, s1_val[k]);
            if (k >= 3 && k <= 5)
                check($sformatf("s1_dat_c%0d", k), link.dataOut, s1_dat[k]);
        end

        // FIFO fill with destination unavailable
        log_q.delete();
        link.outputAvailable = '0;
        push(16'hC801);
        push(16'h0002);
        push(16'h0003);
        push(16'h4004);
        @(negedge clk);
        link.dataIn = 16'h9855;
        #1;
        check("s2_full", link.ready, 0);
        wait_cycles(2);
        #1;
        check("s2_full_hold", link.ready, 0);
        check("s2_noreq", link.requestPort, 0);
        link.outputAvailable = 5'b11111;
        push(16'h9855);
        stop_in();
        wait_cycles(15);
        exp_q = '{ent(5'b00010, 16'hC801), ent(5'b00010, 16'h0002),
                  ent(5'b00010, 16'h0003), ent(5'b00010, 16'h4004),
                  ent(5'b01000, 16'h9855)};
        check_log("s2_log");

        // Mid-packet back-pressure
        log_q.delete();
        push(16'hD0A1);
        push(16'h00A2);
        push(16'h00A3);
        push(16'h40A4);
        check("s3_head_val", link.outValid, 5'b00100);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            link.validIn = 1'b0;
            link.outputReady = 5'b11011;
            #1;
            check("s3_stall_val", link.outValid, 0);
            check("s3_stall_req", link.requestPort, 5'b00100);
        end
        @(negedge clk);
        link.outputReady = 5'b11111;
        wait_cycles(8);
        exp_q = '{ent(5'b00100, 16'hD0A1), ent(5'b00100, 16'h00A2),
                  ent(5'b00100, 16'h00A3), ent(5'b00100, 16'h40A4)};
        check_log("s3_log");

        // Orphan tail then single flit to port 4
        log_q.delete();
        push(16'h4077);
        push(16'hA088);
        first = -1;
        nreq = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            link.validIn = 1'b0;
            #1;
            if (link.requestPort == 5'b10000) begin
                if (first < 0) first = k;
                nreq++;
            end
        end
        check("s4_req_start", first, 1);
        check("s4_req_cycles", nreq, 2);
        exp_q = '{ent(5'b10000, 16'hA088)};
        check_log("s4_log");

        // Head with destination 7
        log_q.delete();
        err_pulses = 0;
        push(16'hF8E1);
        push(16'h00E2);
        push(16'h40E3);
        stop_in();
        wait_cycles(10);
`ifdef INPUT_PORT_ROUTE_ERR_EN
        check("s5_pulses", err_pulses, 1);
        check("s5_errcnt", link.errCount, 1);
        exp_q.delete();
`else
        exp_q = '{ent(5'b10000, 16'hF8E1), ent(5'b10000, 16'h00E2),
                  ent(5'b10000, 16'h40E3)};
`endif
        check_log("s5_log");

        // Reset during TRANSFER with two flits buffered
        link.outputReady = 5'b11011;
        push(16'hD0B1);
        push(16'h00B2);
        stop_in();
        wait_cycles(4);
        #1;
        check("s6_lock", link.requestPort, 5'b00100);
        @(negedge clk);
        link.outputReady = 5'b11111;
        reset_n = 1'b0;
        #1;
        check("s6_rst_req", link.requestPort, 0);
        check("s6_rst_val", link.outValid, 0);
        check("s6_rst_ready", link.ready, 1);
        @(negedge clk);
        reset_n = 1'b1;
        log_q.delete();
        push(16'h8011);
        stop_in();
        wait_cycles(8);
        exp_q = '{ent(5'b00001, 16'h8011)};
        check_log("s6_log");

        check("onehot", viol, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end
endmodule
